// File: rtl/mem_copy_dma.sv
// Bus-initiator block copy engine: moves a run of words from src to dst over the shared memory bus.
// Optional fill mode (write a constant instead of copying) is built only when MEM_COPY_FILL_EN is defined.
module mem_copy_dma #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] read_data,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    logic [2:0]        state;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  idx;
    logic [DATA_W-1:0] data_r;
    logic              fill_mode;
    logic              fill_start;
    logic [DATA_W-1:0] wr_source;
    logic              last_word;

`ifdef MEM_COPY_FILL_EN
    logic              fill_r;
    logic [DATA_W-1:0] fill_value_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_r       <= 1'b0;
            fill_value_r <= '0;
        end else if (state == S_IDLE && start) begin
            fill_r       <= fill;
            fill_value_r <= fill_value;
        end
    end

    assign fill_mode  = fill_r;
    assign fill_start = fill;
    assign wr_source  = fill_r ? fill_value_r : data_r;
`else
    logic unused_fill;
    assign unused_fill = ^{fill, fill_value};
    assign fill_mode   = 1'b0;
    assign fill_start  = 1'b0;
    assign wr_source   = data_r;
`endif

    assign last_word = (idx == cnt_r - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            src_r  <= '0;
            dst_r  <= '0;
            cnt_r  <= '0;
            idx    <= '0;
            data_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_r <= src_addr;
                        dst_r <= dst_addr;
                        cnt_r <= count;
                        idx   <= '0;
                        if (count == '0) begin
                            state <= S_DONE;
                        end else if (fill_start) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    state <= S_RD_WAIT;
                end
                // RAM output is registered, so the word addressed in RD_ADDR is on the bus now.
                S_RD_WAIT: begin
                    data_r <= read_data;
                    state  <= S_WR;
                end
                S_WR: begin
                    if (last_word) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + CNT_W'(1);
                        state <= fill_mode ? S_WR : S_RD_ADDR;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs are decoded from registered state only; addresses wrap modulo 2^ADDR_W.
    always_comb begin
        mem_cmd    = CMD_NONE;
        mem_addr   = '0;
        write_data = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_RD_ADDR, S_RD_WAIT: begin
                mem_cmd  = CMD_READ;
                mem_addr = src_r + ADDR_W'(idx);
                busy     = 1'b1;
            end
            S_WR: begin
                mem_cmd    = CMD_WRITE;
                mem_addr   = dst_r + ADDR_W'(idx);
                write_data = wr_source;
                busy       = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                mem_cmd = CMD_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: bus RAM/I-O model, table of copy vectors, directed corner cases.
// Fill-mode expectations follow MEM_COPY_FILL_EN.
module tb_mem_copy_dma;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  src_addr;
    logic [8:0]  dst_addr;
    logic [7:0]  count;
    logic        fill;
    logic [15:0] fill_value;
    logic [15:0] read_data;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic        busy;
    logic        done;

    mem_copy_dma dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .count      (count),
        .fill       (fill),
        .fill_value (fill_value),
        .read_data  (read_data),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus slave: 256-word RAM with registered output, switches at 0x140, LEDs at 0x100.
    logic [15:0] ram [256];
    logic [15:0] exp_ram [256];
    logic [15:0] sw;
    logic [15:0] ledr;
    logic [15:0] exp_led;

    initial ledr = 16'h0;

    always @(posedge clk) begin
        if (mem_cmd == 2'b10) begin
            if (!mem_addr[8]) ram[mem_addr[7:0]] = write_data;
            else if (mem_addr == 9'h100) ledr = write_data;
        end
        if (mem_addr == 9'h140) read_data <= sw;
        else if (mem_addr[8]) read_data <= 16'h0;
        else read_data <= ram[mem_addr[7:0]];
    end

    int n_compared = 0;
    int n_mismatch = 0;
    logic [8:0] rd_log [$];

    task automatic checkOutput(input string name, input int actual, input int required);
        n_compared++;
        if (actual != required) begin
            n_mismatch++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic logic [15:0] modelRead(input logic [8:0] a);
        if (a == 9'h140) return sw;
        if (a[8]) return 16'h0;
        return exp_ram[a[7:0]];
    endfunction

    task automatic modelWrite(input logic [8:0] a, input logic [15:0] v);
        if (!a[8]) exp_ram[a[7:0]] = v;
        else if (a == 9'h100) exp_led = v;
    endtask

    task automatic modelCopy(input logic [8:0] s, input logic [8:0] d, input logic [7:0] c);
        for (int j = 0; j < int'(c); j++) begin
            modelWrite(d + 9'(j), modelRead(s + 9'(j)));
        end
    endtask

    task automatic checkRam(input string name);
        int diffs;
        diffs = 0;
        for (int k = 0; k < 256; k++) begin
            if (ram[k] !== exp_ram[k]) begin
                if (diffs == 0) $display("[TB] %s first differing word at 0x%0h: %0h vs %0h", name, k, ram[k], exp_ram[k]);
                diffs++;
            end
        end
        checkOutput({name, "_ram_diffs"}, diffs, 0);
        checkOutput({name, "_ledr"}, int'(ledr), int'(exp_led));
    endtask

    // Starts one transfer from a negedge and watches it cycle by cycle until done or timeout.
    task automatic applyStimulus(input logic [8:0] s, input logic [8:0] d, input logic [7:0] c,
                                 input logic f, input logic [15:0] fv,
                                 output int done_cyc, output int busy_cyc, output int n_rd, output int n_wr);
        logic [1:0] prev_cmd;
        int cyc;
        rd_log.delete();
        done_cyc = -1;
        busy_cyc = 0;
        n_rd = 0;
        n_wr = 0;
        prev_cmd = 2'b00;
        src_addr = s;
        dst_addr = d;
        count = c;
        fill = f;
        fill_value = fv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        src_addr = 9'h1AA;
        dst_addr = 9'h155;
        count = 8'hFF;
        cyc = 1;
        while (cyc <= 200) begin
            if (busy) busy_cyc++;
            if (mem_cmd == 2'b01 && prev_cmd != 2'b01) begin
                n_rd++;
                rd_log.push_back(mem_addr);
            end
            if (mem_cmd == 2'b10) n_wr++;
            prev_cmd = mem_cmd;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [8:0] src;
        logic [8:0] dst;
        logic [7:0] cnt;
        int         exp_done;
        int         exp_busy;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int d_cyc, b_cyc, nr, nw, bad;
        string tag;

        vecs[0] = '{src: 9'h010, dst: 9'h040, cnt: 8'd4, exp_done: 13, exp_busy: 12};
        vecs[1] = '{src: 9'h020, dst: 9'h022, cnt: 8'd3, exp_done: 10, exp_busy: 9};
        vecs[2] = '{src: 9'h030, dst: 9'h060, cnt: 8'd1, exp_done: 4,  exp_busy: 3};
        vecs[3] = '{src: 9'h005, dst: 9'h050, cnt: 8'd0, exp_done: 1,  exp_busy: 0};
        vecs[4] = '{src: 9'h140, dst: 9'h100, cnt: 8'd1, exp_done: 4,  exp_busy: 3};
        vecs[5] = '{src: 9'h1FF, dst: 9'h0F0, cnt: 8'd2, exp_done: 7,  exp_busy: 6};
        vecs[6] = '{src: 9'h0FE, dst: 9'h1FF, cnt: 8'd2, exp_done: 7,  exp_busy: 6};

        for (int k = 0; k < 256; k++) begin
            ram[k] = 16'h8000 + 16'(k * 3);
            exp_ram[k] = ram[k];
        end
        ram[8'h10] = 16'h1111; ram[8'h11] = 16'h2222; ram[8'h12] = 16'h3333; ram[8'h13] = 16'h4444;
        for (int k = 8'h10; k <= 8'h13; k++) exp_ram[k] = ram[k];
        sw = 16'h005A;
        exp_led = 16'h0;

        reset = 1'b1;
        start = 1'b0;
        src_addr = 9'h0;
        dst_addr = 9'h0;
        count = 8'h0;
        fill = 1'b0;
        fill_value = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mem_cmd", int'(mem_cmd), 0);
        checkOutput("reset_mem_addr", int'(mem_addr), 0);
        checkOutput("reset_write_data", int'(write_data), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            tag = $sformatf("vec%0d", v);
            modelCopy(vecs[v].src, vecs[v].dst, vecs[v].cnt);
            applyStimulus(vecs[v].src, vecs[v].dst, vecs[v].cnt, 1'b0, 16'h0, d_cyc, b_cyc, nr, nw);
            checkOutput({tag, "_done_cycle"}, d_cyc, vecs[v].exp_done);
            checkOutput({tag, "_busy_cycles"}, b_cyc, vecs[v].exp_busy);
            checkOutput({tag, "_reads"}, nr, int'(vecs[v].cnt));
            checkOutput({tag, "_writes"}, nw, int'(vecs[v].cnt));
            bad = 0;
            for (int j = 0; j < rd_log.size(); j++) begin
                if (rd_log[j] != vecs[v].src + 9'(j)) bad++;
            end
            checkOutput({tag, "_rd_addr_errs"}, bad, 0);
            checkOutput({tag, "_idle_after"}, int'({busy, done, mem_cmd}), 0);
            checkRam(tag);
        end
        checkOutput("io_ledr_from_sw", int'(ledr), 16'h005A);
        checkOutput("wrap_dst0_from_0ff", int'(ram[0]), int'(16'h8000 + 16'(8'hFF * 3)));

        // Reset in the RD_WAIT cycle of word 2: only word 1 lands.
        for (int k = 0; k < 4; k++) begin
            ram[8'h70 + k] = 16'hA700 + 16'(k);
            exp_ram[8'h70 + k] = ram[8'h70 + k];
            ram[8'h80 + k] = 16'hDEAD;
            exp_ram[8'h80 + k] = 16'hDEAD;
        end
        exp_ram[8'h80] = 16'hA700;
        src_addr = 9'h070;
        dst_addr = 9'h080;
        count = 8'd4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_pre_cmd", int'(mem_cmd), 1);
        checkOutput("rst_mid_pre_addr", int'(mem_addr), 9'h071);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_cmd", int'(mem_cmd), 0);
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_addr", int'(mem_addr), 0);
        checkOutput("rst_mid_wdata", int'(write_data), 0);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        checkOutput("rst_mid_no_activity", bad, 0);
        checkRam("rst_mid");

        // Start pulses during the copy and in its DONE cycle are both ignored.
        for (int k = 0; k < 3; k++) begin
            ram[8'h90 + k] = 16'h9900 + 16'(k);
            exp_ram[8'h90 + k] = ram[8'h90 + k];
        end
        modelCopy(9'h090, 9'h0A0, 8'd3);
        src_addr = 9'h090;
        dst_addr = 9'h0A0;
        count = 8'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        d_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 2) begin
                src_addr = 9'h000;
                dst_addr = 9'h0B0;
                count = 8'd5;
                start = 1'b1;
            end else if (c == 3) begin
                start = 1'b0;
            end
            if (done) begin
                d_cyc = c;
                break;
            end
            @(negedge clk);
        end
        checkOutput("busy_start_done_cycle", d_cyc, 10);
        dst_addr = 9'h0C0;
        count = 8'd2;
        start = 1'b1;
        @(negedge clk);
        checkOutput("start_in_done_ignored", int'({busy, mem_cmd}), 0);
        start = 1'b0;
        @(negedge clk);
        checkOutput("still_idle", int'({busy, done, mem_cmd}), 0);
        checkRam("busy_start");

        // Fill request: writes a constant when the feature is built, otherwise behaves as a copy.
`ifdef MEM_COPY_FILL_EN
        for (int k = 0; k < 3; k++) exp_ram[8'h20 + k] = 16'hBEEF;
        applyStimulus(9'h033, 9'h020, 8'd3, 1'b1, 16'hBEEF, d_cyc, b_cyc, nr, nw);
        checkOutput("fill_done_cycle", d_cyc, 4);
        checkOutput("fill_busy_cycles", b_cyc, 3);
        checkOutput("fill_reads", nr, 0);
        checkOutput("fill_writes", nw, 3);
`else
        modelCopy(9'h033, 9'h020, 8'd3);
        applyStimulus(9'h033, 9'h020, 8'd3, 1'b1, 16'hBEEF, d_cyc, b_cyc, nr, nw);
        checkOutput("nofill_done_cycle", d_cyc, 10);
        checkOutput("nofill_busy_cycles", b_cyc, 9);
        checkOutput("nofill_reads", nr, 3);
        checkOutput("nofill_writes", nw, 3);
`endif
        checkRam("fill");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Bus-initiator block copy engine for the RISC memory bus. It drives the same `mem_cmd`/`mem_addr`/`write_data` signals the CPU drives and samples the shared `read_data` bus. It moves a run of 16-bit words from a source address range to a destination address range in RAM or the memory-mapped I/O space. It sits beside the CPU behind the top-level bus mux; the top level grants the bus to the engine while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, default 9: bus address width, matching `mem_addr`. Bit 8 high selects I/O space.
- `DATA_W`, default 16: bus data width.
- `CNT_W`, default 8: width of the word count.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a copy; sampled only in IDLE.
- `src_addr` input ADDR_W: first source word address.
- `dst_addr` input ADDR_W: first destination word address.
- `count` input CNT_W: number of words to move.
- `fill` input 1: fill mode select; used only with `MEM_COPY_FILL_EN`.
- `fill_value` input DATA_W: fill data; used only with `MEM_COPY_FILL_EN`.
- `read_data` input DATA_W: shared bus read data.
- `mem_cmd` output 2: bus command. 00 = NONE, 01 = READ, 10 = WRITE.
- `mem_addr` output ADDR_W: bus address.
- `write_data` output DATA_W: bus write data.
- `busy` output 1: transfer in progress; the engine owns the bus.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, RD_ADDR, RD_WAIT, WR, DONE.
- IDLE:
  - Outputs: `mem_cmd`=00, `busy`=0.
  - When `start`=1, latch `src_addr`, `dst_addr`, `count`, `fill` and `fill_value`, and clear the index `i`.
  - If the latched count is 0, go to DONE. Otherwise go to RD_ADDR, or to WR when fill mode is active.
- RD_ADDR: `mem_cmd`=01, `mem_addr`=src+i. Go to RD_WAIT.
- RD_WAIT:
  - Hold `mem_cmd`=01 and the same `mem_addr`. RAM `dout` is registered, so data is valid in this cycle.
  - Capture `read_data` into the data register at the end of the cycle. Go to WR.
- WR:
  - `mem_cmd`=10, `mem_addr`=dst+i, `write_data`=data register (or `fill_value` in fill mode).
  - If i == count-1, go to DONE. Otherwise increment `i` and go to RD_ADDR (or stay in WR in fill mode).
- DONE: `done`=1, `busy`=0, `mem_cmd`=00. Go to IDLE.
- `busy`=1 in RD_ADDR, RD_WAIT and WR only.
- Address arithmetic is modulo 2^ADDR_W: src+i and dst+i wrap from 0x1FF to 0x000 silently.
- I/O addresses are legal: reading 0x140 returns the switches, and writing 0x100 loads the LEDs.
- Overlapping ranges are copied in ascending order with no overlap protection.
- `start` is ignored outside IDLE, including in DONE. Inputs may change freely after the start cycle.
- `reset` has priority over everything. The next state is IDLE, and all outputs go to their reset values regardless of state, including mid-word.
- Reset values: `mem_cmd`=00, `mem_addr`=0, `write_data`=0, `busy`=0, `done`=0, data register=0, `i`=0.

## Timing
- Outputs are registered or decoded from registered state only; there is no combinational path from an input to any output.
- Copy latency: `start` sampled at edge E0 → first RD_ADDR cycle follows E0.
- A copy takes 3 cycles per word. `done` is high in cycle 3·count+1 after E0.
- A count=0 copy gives `done` in the cycle after E0.
- Each RAM write commits on the edge ending its WR cycle. Each read captures on the edge ending RD_WAIT.
- Back-to-back copies: a new `start` is accepted in the IDLE cycle after DONE, giving a 2-cycle minimum gap.

## Configuration
- `MEM_COPY_FILL_EN` defined:
  - Latched `fill`=1 skips RD_ADDR/RD_WAIT and writes the latched `fill_value` to dst..dst+count-1.
  - Fill mode takes one WR cycle per word. `done` is high in cycle count+1 after E0.
- `MEM_COPY_FILL_EN` undefined:
  - `fill` and `fill_value` ports remain but are ignored, and all transfers are copies.
  - No fill logic is synthesized.

## Test plan
- Basic copy: RAM[0x10..0x13]=0x1111,0x2222,0x3333,0x4444; start with src=0x10, dst=0x40, count=4 → RAM[0x40..0x43] match the source; `done` pulses exactly 13 cycles after the start edge; `busy` high for 12 cycles.
- Zero count: count=0 → `done` in the next cycle; `mem_cmd` never leaves 00; RAM unchanged.
- Wrap and I/O: with SW=0x5A, copy src=0x140, dst=0x100, count=1 → LEDR=0x5A. Separately, copy src=0x1FF, dst=0x0F0, count=2 → reads at 0x1FF then 0x000.
- Reset mid-copy: assert `reset` in the RD_WAIT cycle of word 2 of a count=4 copy → next cycle `mem_cmd`=00, `busy`=0, `done` never pulses; word 1 written, words 2–4 untouched.
- Start while busy: pulse `start` with different addresses during a count=3 copy → ignored; the original copy completes in 10 cycles.
- Fill (with `MEM_COPY_FILL_EN`): fill=1, fill_value=0xBEEF, dst=0x20, count=3 → RAM[0x20..0x22]=0xBEEF; `done` in cycle 4; no READ command issued.
